// File: rtl/sdrc_wb_pkg.sv
// Shared types and constants for the SDRAM-controller Wishbone burst master.
//   wb_state_e      : burst FSM states
//   CTI_*           : Wishbone B3 cycle type identifiers
//   WB_WORD_BYTES   : address step per beat
package sdrc_wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_FETCH = 2'd1,
    WR_STB   = 2'd2,
    RD_STB   = 2'd3
  } wb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int WB_WORD_BYTES = 4;

endpackage

// File: rtl/sdrc_wb_beat_timer.sv
// Per-beat acknowledge timeout counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the counter (takes priority over en)
//   en         : count one strobe cycle without ack
//   expired    : asserted on the TIMEOUT-th consecutive counted cycle
module sdrc_wb_beat_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [9:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 10'd1;
  end

  // Fires in the same cycle the count reaches TIMEOUT, so the master
  // leaves the strobe state on that edge.
  assign expired = en & ~clr & (cnt == 10'(TIMEOUT - 1));

endmodule

// File: rtl/sdrc_wb_burst_master.sv
// Wishbone B3 incrementing-burst initiator for the sdrc_top slave port.
//   wb_clk_i / wb_rst_n           : clock, async active-low reset
//   sdr_init_done                 : gates command acceptance
//   cmd_*                         : one command at a time (we, byte addr, len-1)
//   wdata_valid/ready, wdata/wsel : write beat stream
//   rdata_valid, rdata            : registered read beat stream, no backpressure
//   busy, err                     : burst active, one-cycle timeout-abort pulse
//   wb_*                          : Wishbone master signals
module sdrc_wb_burst_master
  import sdrc_wb_pkg::*;
#(
  parameter int APP_AW  = 26,
  parameter int APP_DW  = 32,
  parameter int APP_BW  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              sdr_init_done,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [APP_DW-1:0] wdata,
  input  logic [APP_BW-1:0] wsel,
  output logic              rdata_valid,
  output logic [APP_DW-1:0] rdata,
  output logic              busy,
  output logic              err,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [APP_DW-1:0] wb_dat_o,
  output logic [APP_BW-1:0] wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [APP_DW-1:0] wb_dat_i
);

  wb_state_e         state_q, state_d;
  logic [APP_AW-1:0] addr_q;
  logic [7:0]        rem_q;
  logic              we_q;
  logic [APP_DW-1:0] dat_q;
  logic [APP_BW-1:0] sel_q;
  logic [APP_DW-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              err_q;

  logic strobing, ack_hit, cmd_fire, fetch_hit, last_beat, expired;
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^cmd_addr[1:0];

  assign strobing  = (state_q == WR_STB) | (state_q == RD_STB);
  // Acks outside a strobe are stray and must not advance the burst.
  assign ack_hit   = wb_ack_i & strobing;
  assign cmd_ready = (state_q == IDLE) & sdr_init_done;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign fetch_hit = (state_q == WR_FETCH) & wdata_valid;
  assign last_beat = (rem_q == 8'd0);

  // Counter is held clear whenever not strobing, which also covers the
  // clear on every entry into a strobe state.
  sdrc_wb_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_n),
    .clr     (~strobing | ack_hit),
    .en      (strobing),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cmd_fire) state_d = cmd_we ? WR_FETCH : RD_STB;
      WR_FETCH: if (wdata_valid) state_d = WR_STB;
      WR_STB, RD_STB: begin
        if (ack_hit)      state_d = last_beat ? IDLE : (we_q ? WR_FETCH : RD_STB);
        else if (expired) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      addr_q        <= '0;
      rem_q         <= '0;
      we_q          <= 1'b0;
      dat_q         <= '0;
      sel_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q <= {cmd_addr[APP_AW-1:2], 2'b00};
        rem_q  <= cmd_len;
        we_q   <= cmd_we;
      end else if (ack_hit) begin
        addr_q <= addr_q + APP_AW'(WB_WORD_BYTES);
        if (!last_beat) rem_q <= rem_q - 8'd1;
      end
      if (fetch_hit) begin
        dat_q <= wdata;
        sel_q <= wsel;
      end
      rdata_valid_q <= ack_hit & ~we_q;
      if (ack_hit & ~we_q) rdata_q <= wb_dat_i;
      err_q <= expired;
    end
  end

  assign busy        = (state_q != IDLE);
  assign wb_cyc_o    = (state_q != IDLE);
  assign wb_stb_o    = strobing;
  assign wb_we_o     = (state_q == WR_STB);
  assign wb_addr_o   = wb_cyc_o ? addr_q : '0;
  assign wb_dat_o    = (state_q == WR_STB) ? dat_q : '0;
  assign wb_sel_o    = (state_q == RD_STB) ? '1 : ((state_q == WR_STB) ? sel_q : '0);
  assign wb_cti_o    = strobing ? (last_beat ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
  assign wdata_ready = fetch_hit;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sdrc_wb_burst_master.sv
module tb_sdrc_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst_n, init_done;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [25:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        rdata_valid, busy, err;
  logic [31:0] rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;

  always #5 clk = ~clk;

  sdrc_wb_burst_master dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .sdr_init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wsel(wsel),
    .rdata_valid(rdata_valid), .rdata(rdata), .busy(busy), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave model + monitor state
  logic [31:0] mem [0:255];
  int          cycn = 0, ack_total = 0, ack_limit = 1 << 30;
  int          ack_cyc[$], rv_cyc[$];
  logic [25:0] ack_addr[$];
  logic [2:0]  ack_cti[$];
  logic [3:0]  ack_sel[$];
  logic [31:0] rv_dat[$];
  int          err_n, err_cyc_hi, gap_n, busy_fall_cyc;
  logic        busy_prev = 1'b0;

  // write-data feeder state
  logic [35:0] wq[$];
  logic        pop = 1'b0;
  int          popped = 0, stall_left = 0;

  // Slave and monitor: everything happens on the falling edge so the DUT
  // samples stable ack/data at the next rising edge.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      cycn++;
      if (wb_ack_i) wb_ack_i = 1'b0;
      else if (wb_cyc_o && wb_stb_o && ack_total < ack_limit) begin
        wb_ack_i = 1'b1;
        ack_total++;
        ack_cyc.push_back(cycn);
        ack_addr.push_back(wb_addr_o);
        ack_cti.push_back(wb_cti_o);
        ack_sel.push_back(wb_sel_o);
        if (wb_we_o) mem[wb_addr_o[9:2]] = wb_dat_o;
        else         wb_dat_i = mem[wb_addr_o[9:2]];
      end
      if (rdata_valid) begin
        rv_cyc.push_back(cycn);
        rv_dat.push_back(rdata);
      end
      if (err) begin
        err_n++;
        if (wb_cyc_o || wb_stb_o) err_cyc_hi++;
      end
      if (wb_cyc_o && !wb_stb_o) gap_n++;
      if (busy_prev && !busy) busy_fall_cyc = cycn;
      busy_prev = busy;
    end
  end

  // Write-data source; optionally withholds data for stall_left fetch cycles
  // before the third beat.
  initial begin
    wdata_valid = 1'b0;
    wdata = '0;
    wsel = '0;
    forever begin
      @(negedge clk);
      if (pop) begin
        void'(wq.pop_front());
        popped++;
      end
      if (wq.size() > 0 && !(popped == 2 && stall_left > 0)) begin
        wdata_valid = 1'b1;
        {wsel, wdata} = wq[0];
      end else begin
        wdata_valid = 1'b0;
        if (popped == 2 && stall_left > 0 && wb_cyc_o && !wb_stb_o) stall_left--;
      end
      #1 pop = wdata_valid & wdata_ready;
    end
  end

  task automatic clear_logs();
    ack_cyc.delete(); ack_addr.delete(); ack_cti.delete(); ack_sel.delete();
    rv_cyc.delete(); rv_dat.delete();
    err_n = 0; err_cyc_hi = 0; gap_n = 0; busy_fall_cyc = -1; popped = 0;
  endtask

  task automatic run_cmd(input string tag, input logic we, input logic [25:0] a,
                         input logic [7:0] len);
    int n;
    @(negedge clk);
    clear_logs();
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_done"}, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  logic seen;

  initial begin
    rst_n = 1'b0; init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_len = '0;
    repeat (4) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_cti", wb_cti_o, 3'b000);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy_err_rv", {busy, err, rdata_valid}, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen |= cmd_ready | wb_cyc_o | wb_stb_o | wb_we_o | (|wb_addr_o) | (|wb_sel_o) | (|wb_cti_o);
    end
    chk("pre_init_quiet", seen, 0);
    init_done = 1'b1;
    @(negedge clk); #1;
    chk("init_cmd_ready", cmd_ready, 1);

    // 8-beat write
    for (int i = 0; i < 8; i++) wq.push_back({4'hF, 32'h11111111 * (i + 1)});
    run_cmd("wr8", 1'b1, 26'h0040000, 8'd7);
    chk("wr8_beats", ack_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr8_addr%0d", i), ack_addr[i], 26'h0040000 + 4 * i);
      chk($sformatf("wr8_cti%0d", i), ack_cti[i], (i < 7) ? 3'b010 : 3'b111);
      chk($sformatf("wr8_mem%0d", i), mem[i], 32'h11111111 * (i + 1));
    end
    chk("wr8_busy_fall", busy_fall_cyc, ack_cyc[7] + 1);
    chk("wr8_err", err_n, 0);

    // 8-beat read back
    run_cmd("rd8", 1'b0, 26'h0040000, 8'd7);
    chk("rd8_rv_count", rv_dat.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd8_dat%0d", i), rv_dat[i], 32'h11111111 * (i + 1));
      chk($sformatf("rd8_lat%0d", i), rv_cyc[i], ack_cyc[i] + 1);
      chk($sformatf("rd8_sel%0d", i), ack_sel[i], 4'hF);
    end

    // write with a 5-cycle data stall before beat 3
    for (int i = 0; i < 5; i++) wq.push_back({4'(i + 1), 32'hA0000000 + i});
    stall_left = 5;
    run_cmd("stall", 1'b1, 26'h0040100, 8'd4);
    chk("stall_beats", ack_addr.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_addr%0d", i), ack_addr[i], 26'h0040100 + 4 * i);
      chk($sformatf("stall_sel%0d", i), ack_sel[i], 4'(i + 1));
      chk($sformatf("stall_mem%0d", i), mem[8'h40 + i], 32'hA0000000 + i);
    end
    chk("stall_gap", gap_n, 10);
    chk("stall_err", err_n, 0);

    // ack withheld on beat 2 of a 4-beat read
    ack_limit = ack_total + 1;
    run_cmd("tmo", 1'b0, 26'h0040000, 8'd3);
    ack_limit = 1 << 30;
    chk("tmo_err_pulses", err_n, 1);
    chk("tmo_err_cyc", err_cyc_hi, 0);
    chk("tmo_rv_count", rv_dat.size(), 1);
    chk("tmo_rv_dat", rv_dat[0], 32'h11111111);
    chk("tmo_idle", {wb_cyc_o, wb_stb_o, busy, cmd_ready}, 4'b0001);

    // init_done low blocks commands
    init_done = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (4) @(negedge clk);
    chk("noinit_ready", cmd_ready, 0);
    chk("noinit_busy", busy, 0);
    cmd_valid = 1'b0;
    init_done = 1'b1;

    // single beat at top of address space, then wrap
    wq.push_back({4'h3, 32'hCAFEF00D});
    run_cmd("top1", 1'b1, 26'h3FFFFFF, 8'd0);
    chk("top1_beats", ack_addr.size(), 1);
    chk("top1_addr", ack_addr[0], 26'h3FFFFFC);
    chk("top1_cti", ack_cti[0], 3'b111);
    chk("top1_sel", ack_sel[0], 4'h3);
    chk("top1_mem", mem[255], 32'hCAFEF00D);
    wq.push_back({4'hF, 32'h01234567});
    wq.push_back({4'hF, 32'h89ABCDEF});
    run_cmd("wrap", 1'b1, 26'h3FFFFFC, 8'd1);
    chk("wrap_beats", ack_addr.size(), 2);
    chk("wrap_addr0", ack_addr[0], 26'h3FFFFFC);
    chk("wrap_addr1", ack_addr[1], 26'h0000000);
    chk("wrap_cti0", ack_cti[0], 3'b010);
    chk("wrap_cti1", ack_cti[1], 3'b111);
    chk("wrap_mem0", mem[0], 32'h89ABCDEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdrc_wb_burst_master.md
Name: sdrc_wb_burst_master

Overview:
- Synthesizable Wishbone B3 initiator that drives the Wishbone slave port of sdrc_top.
- Accepts one command at a time (write or read, 1..256 beats) and turns it into an incrementing-address Wishbone burst.
- Write data comes in on a valid/ready stream; read data goes out as a registered valid stream.
- Instantiated between a traffic source (bench driver or on-chip client) and the SDRAM controller.

Parameters:
- APP_AW, 26, Wishbone byte-address width.
- APP_DW, 32, Wishbone data width.
- APP_BW, 4, byte-select width (APP_DW/8).
- TIMEOUT, 255, idle cycles allowed per beat waiting for wb_ack_i before abort; range 1..1023.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_n  in  1  asynchronous active-low reset.
- sdr_init_done  in  1  SDRAM initialisation complete; no command is accepted while low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command.
- cmd_we  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  APP_AW  start byte address; low 2 bits ignored (forced 0).
- cmd_len  in  8  beat count minus one.
- wdata_valid  in  1  write data available.
- wdata_ready  out  1  write beat consumed this cycle.
- wdata  in  APP_DW  write data.
- wsel  in  APP_BW  byte enables for the write beat.
- rdata_valid  out  1  read beat valid (one-cycle pulse per beat).
- rdata  out  APP_DW  read data.
- busy  out  1  burst in progress.
- err  out  1  one-cycle pulse on timeout abort.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle, strobe, write enable.
- wb_addr_o  out  APP_AW  Wishbone address.
- wb_dat_o  out  APP_DW  Wishbone write data.
- wb_sel_o  out  APP_BW  Wishbone byte selects.
- wb_cti_o  out  3  cycle type identifier.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_dat_i  in  APP_DW  Wishbone read data.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, except wb_cti_o = 3'b000 and cmd_ready = 0.
- cmd_ready = (state==IDLE) & sdr_init_done. A command is accepted on cmd_valid & cmd_ready.
- On accept, latch the following:
  - addr = {cmd_addr[APP_AW-1:2], 2'b00}
  - remaining = cmd_len
  - we = cmd_we
- After accept, go to WR_FETCH if writing, else RD_STB.
- WR_FETCH:
  - wb_cyc_o = 1, wb_stb_o = 0, wdata_ready = wdata_valid.
  - On wdata_valid, latch wdata/wsel into wb_dat_o/wb_sel_o and go to WR_STB.
- WR_STB:
  - wb_stb_o = 1, wb_we_o = 1; address, data and sel held stable until ack.
- RD_STB:
  - wb_cyc_o = wb_stb_o = 1, wb_we_o = 0, wb_sel_o = all ones.
  - On ack: rdata <= wb_dat_i and rdata_valid = 1 on the following cycle (1-cycle latency). There is no read backpressure.
- wb_cti_o while strobing: 3'b010 if remaining != 0, 3'b111 on the last beat.
- On each ack:
  - addr += 4, wrapping modulo 2^APP_AW.
  - If remaining == 0: drop cyc/stb the next cycle and return to IDLE.
  - Otherwise: remaining -= 1 and continue (WR_FETCH or RD_STB).
  - wb_cyc_o stays high across the whole burst, including WR_FETCH gaps.
- Timeout:
  - Per-beat counter clears on every ack and on every entry into a strobe state.
  - It increments while strobing without ack.
  - Reaching TIMEOUT forces cyc/stb low, pulses err for 1 cycle, and returns to IDLE; the rest of the burst is discarded.
  - The counter does not run in WR_FETCH.
- An ack received while stb = 0 is ignored.
- sdr_init_done falling mid-burst does not abort; it blocks only new commands.
- busy = (state != IDLE).
- cmd_len = 0 gives a single beat with cti = 3'b111.
- Reset mid-burst drops cyc/stb immediately (async).

Decomposition:
- Package sdrc_wb_pkg holds:
  - state enum {IDLE, WR_FETCH, WR_STB, RD_STB}
  - CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111
  - WB_WORD_BYTES = 4
- Sub-module sdrc_wb_beat_timer holds the per-beat timeout counter, with clear/enable inputs and an expired output.

Test Plan:
- Reset held low with sdr_init_done = 0, then released and init_done raised after 100 cycles → cmd_ready stays 0 until init_done = 1, then goes to 1; all Wishbone outputs stay 0 throughout.
- Write cmd addr = 0x40000, len = 7, wdata 0x11111111..0x88888888 → 8 acked beats at 0x40000..0x4001C, cti 010×7 then 111, cyc continuous, busy falls 1 cycle after the 8th ack.
- Read cmd addr = 0x40000, len = 7 after the write → 8 rdata_valid pulses returning 0x11111111..0x88888888 in order, each 1 cycle after its ack.
- Write with wdata_valid stalled 5 cycles before beat 3 → cyc held, stb low during the stall, no err, addresses still contiguous.
- Slave ack held off for 255 cycles on beat 2 of a len = 3 read → err pulses once, cyc/stb drop, state returns to IDLE, only 1 rdata_valid seen.
- Single-beat write at addr = 0x3FFFFFF (2 LSBs ignored) followed by len = 1 → first beat addr 0x3FFFFFC with cti 111; second command wraps to 0x0000000.
